// File: rtl/twos_block_accum.sv
//------------------------------------------------------------------------------
// Module   : twos_block_accum
// Brief    : Sums blocks of NUM two's-complement samples (or fewer on flush)
//            and presents each sum with its sample count on a valid/ready port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module twos_block_accum #(
    parameter int MIC = 3,
    parameter int NUM = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MIC-1:0]   in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [MIC+3:0]   out_sum,
    output logic [4:0]       out_cnt,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int         C_SW  = MIC + 4;
    localparam logic [4:0] C_NUM = 5'(NUM);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [C_SW-1:0]   acc_q, acc_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [C_SW-1:0]   sum_q, sum_d;
    logic [4:0]        ocnt_q, ocnt_d;

    logic              w_accept;
    logic [C_SW-1:0]   w_ext;
    logic [C_SW-1:0]   w_acc_new;
    logic [4:0]        w_cnt_new;
    logic              w_close;

    // Plain sign extension: 1000..0 is the most-negative value, not -0.
    assign w_ext     = {{4{in_data[MIC-1]}}, in_data};
    assign w_accept  = in_valid && (state_q == ST_ACCUM);
    assign w_acc_new = w_accept ? (acc_q + w_ext) : acc_q;
    assign w_cnt_new = w_accept ? (cnt_q + 5'd1) : cnt_q;
    assign w_close   = (w_accept && (w_cnt_new == C_NUM)) ||
                       (flush && (w_cnt_new != 5'd0));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        ocnt_d  = ocnt_q;
        case (state_q)
            ST_ACCUM: begin
                acc_d = w_acc_new;
                cnt_d = w_cnt_new;
                if (w_close) begin
                    sum_d   = w_acc_new;
                    ocnt_d  = w_cnt_new;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ocnt_q  <= ocnt_d;
        end
    end

    // Handshake outputs depend only on state (and reset), never on the inputs.
    assign in_ready  = (state_q == ST_ACCUM) && !rst;
    assign out_valid = (state_q == ST_HOLD);
    assign out_sum   = sum_q;
    assign out_cnt   = ocnt_q;

endmodule

`default_nettype wire

// File: tb/tb_twos_block_accum.sv
//------------------------------------------------------------------------------
// Module   : tb_twos_block_accum
// Brief    : Scoreboard bench for twos_block_accum (MIC=3, NUM=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_twos_block_accum;

    localparam int MIC = 3;
    localparam int NUM = 4;

    typedef struct {
        logic [MIC+3:0] sum;
        logic [4:0]     cnt;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [MIC-1:0] in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           flush = 1'b0;
    logic [MIC+3:0] out_sum;
    logic [4:0]     out_cnt;
    logic           out_valid;
    logic           out_ready = 1'b0;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    twos_block_accum #(.MIC(MIC), .NUM(NUM)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int s, input int c);
        exp_t e;
        e.sum = (MIC+4)'(s);
        e.cnt = 5'(c);
        exp_q.push_back(e);
    endtask

    // Monitor: compare each output handshake against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got sum=%0h cnt=%0d expected none", out_sum, out_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_sum", 32'(out_sum), 32'(e.sum));
                chk("out_cnt", 32'(out_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic step(input logic v, input logic [MIC-1:0] d, input logic f,
                        input logic r, output logic acc_o);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        @(negedge clk);
        acc_o = v && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [MIC-1:0] d);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 20 && !a; i++) step(1'b1, d, 1'b0, 1'b1, a);
        if (!a) chk("feed_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 20; i++) begin
            if (!out_valid) return;
            step(1'b0, '0, 1'b0, 1'b1, a);
        end
        chk("drain_timeout", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic a;
        int   m_acc, m_cnt, s;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 3 + (-1) + 2 + (-4) = 0
        push_exp(0, 4);
        feed(3'd3); feed(3'd7); feed(3'd2); feed(3'd4);
        chk("close_out_valid", 32'(out_valid), 32'd1);
        chk("close_in_ready", 32'(in_ready), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1, a);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);

        // Extremes: 4*3 = 12 and 4*(-4) = -16
        push_exp(12, 4);
        repeat (4) feed(3'd3);
        drain();
        push_exp(-16, 4);
        repeat (4) feed(3'd4);

        // Backpressure for 5 cycles with in_valid pulses
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 3'd1, 1'b0, 1'b0, a);
            chk("bp_accept", 32'(a), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_sum", 32'(out_sum), 32'h70);
            chk("bp_out_cnt", 32'(out_cnt), 32'd4);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        drain();

        // Flush with no sample in the flush cycle
        push_exp(3, 2);
        feed(3'd1); feed(3'd2);
        step(1'b0, '0, 1'b1, 1'b1, a);
        chk("flush_out_valid", 32'(out_valid), 32'd1);
        drain();

        // Flush together with a sample: 1 + (-3) = -2
        push_exp(-2, 2);
        feed(3'd1);
        step(1'b1, 3'd5, 1'b1, 1'b1, a);
        chk("flush_acc_accept", 32'(a), 32'd1);
        drain();

        // Flush with empty block is ignored
        step(1'b0, '0, 1'b1, 1'b1, a);
        chk("flush0_out_valid", 32'(out_valid), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1, a);
        chk("flush0_out_valid2", 32'(out_valid), 32'd0);

        // Reset with a partial block
        feed(3'd3); feed(3'd3);
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, a);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_sum", 32'(out_sum), 32'd0);
        chk("mid_rst_out_cnt", 32'(out_cnt), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        push_exp(4, 4);
        repeat (4) feed(3'd1);
        drain();

        // Reset with a pending result in HOLD
        repeat (4) feed(3'd2);
        out_ready = 1'b0;
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, a);
        rst = 1'b0;
        #1;
        chk("hold_rst_out_valid", 32'(out_valid), 32'd0);
        chk("hold_rst_out_sum", 32'(out_sum), 32'd0);
        chk("hold_rst_out_cnt", 32'(out_cnt), 32'd0);
        push_exp(-4, 4);
        repeat (4) feed(3'd7);
        drain();

        // Random handshakes with a sum model
        m_acc = 0;
        m_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            logic [MIC-1:0] d;
            d = MIC'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), d, 1'b0, 1'($urandom_range(0, 1)), a);
            if (a) begin
                s = d[MIC-1] ? int'(d) - (1 << MIC) : int'(d);
                m_acc += s;
                m_cnt++;
                if (m_cnt == NUM) begin
                    push_exp(m_acc, m_cnt);
                    m_acc = 0;
                    m_cnt = 0;
                end
            end
        end
        if (m_cnt > 0) begin
            push_exp(m_acc, m_cnt);
            step(1'b0, '0, 1'b1, 1'b1, a);
        end
        drain();
        repeat (2) step(1'b0, '0, 1'b0, 1'b1, a);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
